// File: rtl/rv32i_core_sequencer.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/execute/memory/writeback,
// owns the PC, the single-port memory handshake, register-file write enable and instret.
module rv32i_core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        br_taken,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        halted,
    output logic [1:0]  err_code
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      target_q;
    logic             started;   // low for the cycle after reset so strobes stay quiet
    logic             active;
    logic             is_legal;
    logic             is_jump;
    logic             redirect;
    logic             misaligned;
    logic [31:0]      pc_plus4;
    logic [31:0]      target;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        is_legal = 1'b0;
        target   = pc_plus4;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_OPIMM,
            OP_OP, OP_FENCE, OP_SYSTEM: is_legal = 1'b1;
            OP_JAL: begin
                is_legal = 1'b1;
                target   = pc + imm;
            end
            OP_JALR: begin
                is_legal = 1'b1;
                target   = alu_result & ~32'd1;
            end
            OP_BRANCH: begin
                is_legal = 1'b1;
                target   = br_taken ? pc + imm : pc_plus4;
            end
            default: ;
        endcase
    end

    assign pc_plus4   = pc + 32'd4;
    assign is_jump    = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign redirect   = is_jump || ((opcode == OP_BRANCH) && br_taken);
    assign misaligned = redirect && (target[1:0] != 2'b00);

    // Strobes come straight from the registered state, gated by reset and the startup cycle.
    assign active       = started && !rst;
    assign mem_req      = active && ((state == S_FETCH) || (state == S_MEM));
    assign mem_we       = active && (state == S_MEM) && (opcode == OP_STORE);
    assign mem_addr_sel = (state == S_MEM);
    assign ir_we        = active && (state == S_FETCH) && mem_ack;
    assign rf_we        = active && (state == S_WB);
    assign halted       = (state == S_HALT);
    assign wb_sel       = (opcode == OP_LOAD) ? 2'd1 : (is_jump ? 2'd2 : 2'd0);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            instret  <= 32'd0;
            err_code <= 2'd0;
            wait_cnt <= '0;
            target_q <= 32'd0;
            started  <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                S_FETCH, S_MEM: begin
                    if (started) begin
                        if (mem_ack) begin
                            wait_cnt <= '0;
                            if (state == S_FETCH) begin
                                state <= S_DECODE;
                            end else if (opcode == OP_STORE) begin
                                pc      <= pc_plus4;
                                instret <= instret + 32'd1;
                                state   <= S_FETCH;
                            end else begin
                                state <= S_WB;
                            end
                        end else if (wait_cnt == WAIT_LAST) begin
                            wait_cnt <= '0;
                            err_code <= 2'd2;
                            state    <= S_HALT;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DECODE: begin
                    if (is_legal) begin
                        state <= S_EXEC;
                    end else begin
                        err_code <= 2'd1;
                        state    <= S_HALT;
                    end
                end
                S_EXEC: begin
                    target_q <= target;
                    if (misaligned) begin
                        err_code <= 2'd3;
                        state    <= S_HALT;
                    end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                        state <= S_MEM;
                    end else if ((opcode == OP_BRANCH) || (opcode == OP_FENCE)) begin
                        pc      <= target;
                        instret <= instret + 32'd1;
                        state   <= S_FETCH;
                    end else if (opcode == OP_SYSTEM) begin
                        err_code <= 2'd0;
                        state    <= S_HALT;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    pc      <= is_jump ? target_q : pc_plus4;
                    instret <= instret + 32'd1;
                    state   <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule
